// File: rtl/ascii_frame_loader.sv
// Collects '/'-prefixed frames of NDIG ASCII symbols (0-9, ':') from a byte stream
// and commits them atomically to digits_o; malformed or stalled frames raise err_o.
module ascii_frame_loader #(
    parameter int NDIG    = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [4*NDIG-1:0]   digits_o,
    output logic                load_o,
    output logic                err_o
);

    localparam int IW = $clog2(NDIG + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [4*NDIG-1:0]   shadow_reg, shadow_next;
    logic [4*NDIG-1:0]   digits_reg, digits_next;
    logic                load_reg, load_next;
    logic                err_reg, err_next;
    logic                ready_reg, ready_next;

    logic                accept;
    logic                is_slash;
    logic                is_sym;
    logic [3:0]          code;

    assign accept   = rx_valid && ready_reg;
    assign is_slash = (rx_data == 8'h2F);

    // Symbol decode: '/' is only a frame marker, never stored as data.
    always_comb begin
        is_sym = 1'b0;
        code   = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_sym = 1'b1;
            code   = rx_data[3:0];
        end else if (rx_data == 8'h3A) begin
            is_sym = 1'b1;
            code   = 4'hA;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        shadow_next = shadow_reg;
        digits_next = digits_reg;
        load_next   = 1'b0;
        err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept && is_slash) begin
                    idx_next   = '0;
                    cnt_next   = '0;
                    state_next = COLLECT;
                end
            end

            COLLECT: begin
                if (accept) begin
                    cnt_next = '0;
                    if (is_sym) begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (idx_reg == IW'(i)) begin
                                shadow_next[4*(NDIG-1-i) +: 4] = code;
                            end
                        end
                        if (idx_reg == IW'(NDIG - 1)) begin
                            // Commit the completed buffer, including the final nibble, on this edge.
                            digits_next = shadow_next;
                            load_next   = 1'b1;
                            idx_next    = '0;
                            state_next  = COMMIT;
                        end else begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end else if (is_slash) begin
                        idx_next = '0;
                    end else begin
                        err_next    = 1'b1;
                        idx_next    = '0;
                        shadow_next = '0;
                        state_next  = IDLE;
                    end
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    err_next    = 1'b1;
                    cnt_next    = '0;
                    idx_next    = '0;
                    shadow_next = '0;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            COMMIT: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Back-pressure exactly during the commit cycle.
    assign ready_next = (state_next != COMMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            digits_reg <= '0;
            load_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
            digits_reg <= digits_next;
            load_reg   <= load_next;
            err_reg    <= err_next;
            ready_reg  <= ready_next;
        end
    end

    assign rx_ready = ready_reg;
    assign digits_o = digits_reg;
    assign load_o   = load_reg;
    assign err_o    = err_reg;

endmodule

// File: tb/tb_ascii_frame_loader.sv
// Directed bench for ascii_frame_loader: stimulus pushes expected load/err events,
// an independent monitor pops and compares them whenever the DUT pulses.
module tb_ascii_frame_loader;

    localparam int NDIG    = 6;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic [4*NDIG-1:0]   digits_o;
    logic                load_o;
    logic                err_o;

    ascii_frame_loader #(.NDIG(NDIG), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .digits_o (digits_o),
        .load_o   (load_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 is_err;
        logic [4*NDIG-1:0]  digits;
    } event_t;

    event_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic expect_load(input logic [4*NDIG-1:0] d);
        event_t e;
        e.is_err = 1'b0;
        e.digits = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        event_t e;
        e.is_err = 1'b1;
        e.digits = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: every load/err pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (load_o || err_o)) begin
            event_t e;
            if (load_o && err_o) begin
                check("load_err_exclusive", 32'd1, 32'd0);
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, load_o, err_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_is_err", {31'd0, err_o}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check("event_digits", {8'd0, digits_o}, {8'd0, e.digits});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b, output int waited);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            check("send_ready_timeout", 32'(waited), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        int seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_digits", {8'd0, digits_o}, 32'd0);
        check("rst_load", {31'd0, load_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

        // Back-to-back frame; load exactly one cycle after the last byte
        expect_load(24'h12A345);
        send_str("/12:345");
        check("a_load_commit_cycle", {31'd0, load_o}, 32'd1);
        check("a_ready_commit_cycle", {31'd0, rx_ready}, 32'd0);
        check("a_digits", {8'd0, digits_o}, 32'h0012A345);
        @(negedge clk);
        check("a_load_one_cycle", {31'd0, load_o}, 32'd0);
        check("a_ready_back", {31'd0, rx_ready}, 32'd1);

        // Restart mid-frame: single load, no error
        expect_load(24'h987654);
        send_str("/12/987654");
        idle(3);
        check("b_digits", {8'd0, digits_o}, 32'h00987654);

        // Invalid byte aborts, digits retained, next frame loads
        expect_err();
        send_str("/1A");
        check("c_err_pulse", {31'd0, err_o}, 32'd1);
        check("c_digits_kept", {8'd0, digits_o}, 32'h00987654);
        @(negedge clk);
        check("c_err_one_cycle", {31'd0, err_o}, 32'd0);
        expect_load(24'h314159);
        send_str("/314159");
        idle(2);
        check("c_next_frame", {8'd0, digits_o}, 32'h00314159);

        // Timeout after TIMEOUT idle cycles
        expect_err();
        send_str("/1");
        seen = 0;
        for (int i = 1; i <= 20 && seen == 0; i++) begin
            @(negedge clk);
            if (err_o) seen = i;
        end
        check("d_timeout_cycle", 32'(seen), 32'(TIMEOUT));
        check("d_digits_kept", {8'd0, digits_o}, 32'h00314159);

        // One idle cycle short of timeout: no error
        expect_load(24'h12A007);
        send_str("/1");
        idle(TIMEOUT - 1);
        send_str("2:007");
        idle(2);
        check("e_no_timeout_load", {8'd0, digits_o}, 32'h0012A007);

        // rx_valid held across COMMIT: held off exactly one cycle
        expect_load(24'h111111);
        expect_load(24'h222222);
        send_str("/111111");
        send(8'h2F, w);
        check("f_holdoff_cycles", 32'(w), 32'd1);
        send_str("222222");
        idle(2);
        check("f_second_frame", {8'd0, digits_o}, 32'h00222222);

        // Reset mid-frame after 3 symbols
        send_str("/777");
        rst = 1'b1;
        @(negedge clk);
        check("g_rst_digits", {8'd0, digits_o}, 32'd0);
        check("g_rst_load", {31'd0, load_o}, 32'd0);
        check("g_rst_err", {31'd0, err_o}, 32'd0);
        check("g_rst_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_load(24'h543210);
        send_str("/543210");
        idle(3);
        check("g_fresh_frame", {8'd0, digits_o}, 32'h00543210);

        idle(TIMEOUT + 4);
        check("pending_events", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
